// File: rtl/rvx10_mem_pkg.sv
// rvx10_mem_pkg: shared types and constants for the unified memory arbiter
package rvx10_mem_pkg;
    typedef enum logic [1:0] {IDLE, BUSY_I, BUSY_D} arb_state_t;
    typedef enum logic {OWN_I, OWN_D} owner_t;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;
endpackage

// File: rtl/mem_wdog.sv
// mem_wdog: per-transfer wait counter that flags a transfer exceeding TIMEOUT wait cycles
//   clk_i, reset_i : clock, synchronous active-high reset
//   clear_i        : restart the count (held while the master is idle)
//   count_i        : one more wait cycle elapsed
//   expired_o      : count has reached TIMEOUT (never set when TIMEOUT is 0)
module mem_wdog #(
    parameter int TIMEOUT = 255
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic clear_i,
    input  logic count_i,
    output logic expired_o
);
    localparam int W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [W-1:0] LIMIT = W'(TIMEOUT);
    logic [W-1:0] cnt_q, cnt_d;
    assign expired_o = (TIMEOUT != 0) && (cnt_q == LIMIT);
    always_comb cnt_d = clear_i ? '0 : (count_i && !expired_o) ? cnt_q + W'(1) : cnt_q;
    always_ff @(posedge clk_i) begin
        if (reset_i) cnt_q <= '0;
        else         cnt_q <= cnt_d;
    end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between fetch (IF) and data (MEM) with MEM priority
//   if_req_i/if_addr_i -> if_rdata_o/if_valid_o : fetch request and one-cycle completion
//   d_req_i/d_we_i/d_addr_i/d_wdata_i -> d_rdata_o/d_valid_o : load/store request and completion
//   stall_f_o, stall_m_o : per-stage stalls while a request is outstanding
//   m_req_o/m_we_o/m_addr_o/m_wdata_o, m_ready_i/m_rdata_i : memory req/ready handshake
//   bus_err_o : sticky watchdog-abort flag
module mem_arbiter
    import rvx10_mem_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic          clk_i,
    input  logic          reset_i,
    input  logic          if_req_i,
    input  logic [AW-1:0] if_addr_i,
    output logic [DW-1:0] if_rdata_o,
    output logic          if_valid_o,
    input  logic          d_req_i,
    input  logic          d_we_i,
    input  logic [AW-1:0] d_addr_i,
    input  logic [DW-1:0] d_wdata_i,
    output logic [DW-1:0] d_rdata_o,
    output logic          d_valid_o,
    output logic          stall_f_o,
    output logic          stall_m_o,
    output logic          m_req_o,
    output logic          m_we_o,
    output logic [AW-1:0] m_addr_o,
    output logic [DW-1:0] m_wdata_o,
    input  logic          m_ready_i,
    input  logic [DW-1:0] m_rdata_i,
    output logic          bus_err_o
);
    arb_state_t    state_q, state_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic          we_q, we_d;
    logic          bus_err_q, bus_err_d;
    logic          busy, expired, done;
    owner_t        owner;

    mem_wdog #(.TIMEOUT(TIMEOUT)) u_wdog (
        .clk_i    (clk_i),
        .reset_i  (reset_i),
        .clear_i  (state_q == IDLE),
        .count_i  (busy && !m_ready_i),
        .expired_o(expired)
    );

    assign busy  = state_q != IDLE;
    assign owner = (state_q == BUSY_D) ? OWN_D : OWN_I;
    // An expired transfer completes without touching memory: m_req drops that cycle.
    assign m_req_o   = busy && !expired && !reset_i;
    assign m_we_o    = m_req_o && we_q;
    assign m_addr_o  = addr_q;
    assign m_wdata_o = wdata_q;
    assign done      = busy && !reset_i && (expired || m_ready_i);
    assign if_valid_o = done && owner == OWN_I;
    assign d_valid_o  = done && owner == OWN_D;
    assign if_rdata_o = expired ? DW'(NOP_INSTR) : m_rdata_i;
    assign d_rdata_o  = expired ? '0 : m_rdata_i;
    assign stall_f_o  = if_req_i && !if_valid_o;
    assign stall_m_o  = d_req_i && !d_valid_o;
    assign bus_err_o  = bus_err_q;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        we_d      = we_q;
        bus_err_d = bus_err_q || (busy && expired);
        if (state_q == IDLE) begin
            if (d_req_i) begin
                state_d = BUSY_D;
                addr_d  = d_addr_i;
                wdata_d = d_wdata_i;
                we_d    = d_we_i;
            end else if (if_req_i) begin
                state_d = BUSY_I;
                addr_d  = if_addr_i;
                we_d    = 1'b0;
            end
        end else if (done) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= IDLE;
            addr_q    <= '0;
            wdata_q   <= '0;
            we_q      <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            we_q      <= we_d;
            bus_err_q <= bus_err_d;
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed self-checking bench for mem_arbiter with a wait-state memory model
module tb_mem_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    logic        if_req, if_valid, d_req, d_we, d_valid;
    logic        stall_f, stall_m, m_req, m_we, m_ready, bus_err;
    logic [31:0] if_addr, if_rdata, d_addr, d_wdata, d_rdata, m_addr, m_wdata, m_rdata;
    logic [31:0] mem [0:255];
    logic        init_mem, hang;
    int          wait_n, wcnt;
    int          n_chk = 0, n_fail = 0, both_hi = 0, dv_cnt = 0, iv_cnt = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.AW(32), .DW(32), .TIMEOUT(4)) dut (
        .clk_i     (clk),
        .reset_i   (reset),
        .if_req_i  (if_req),
        .if_addr_i (if_addr),
        .if_rdata_o(if_rdata),
        .if_valid_o(if_valid),
        .d_req_i   (d_req),
        .d_we_i    (d_we),
        .d_addr_i  (d_addr),
        .d_wdata_i (d_wdata),
        .d_rdata_o (d_rdata),
        .d_valid_o (d_valid),
        .stall_f_o (stall_f),
        .stall_m_o (stall_m),
        .m_req_o   (m_req),
        .m_we_o    (m_we),
        .m_addr_o  (m_addr),
        .m_wdata_o (m_wdata),
        .m_ready_i (m_ready),
        .m_rdata_i (m_rdata),
        .bus_err_o (bus_err)
    );

    assign m_ready = m_req && !hang && (wcnt == wait_n);
    assign m_rdata = mem[m_addr[9:2]];

    always @(posedge clk) begin
        if (init_mem) begin
            mem[0]  <= 32'h0000_00A0;
            mem[1]  <= 32'h0000_00A1;
            mem[2]  <= 32'h0000_00A2;
            mem[16] <= 32'h0000_1234;
            mem[20] <= 32'h0000_5050;
            mem[21] <= 32'h0000_5151;
            mem[22] <= 32'h0000_5252;
            mem[28] <= 32'h0000_0777;
        end else if (m_req && m_ready && m_we) begin
            mem[m_addr[9:2]] <= m_wdata;
        end
        wcnt <= (!m_req || m_ready) ? 0 : wcnt + 1;
    end

    always @(negedge clk) begin
        if (if_valid && d_valid) both_hi++;
        if (d_valid) dv_cnt++;
        if (if_valid) iv_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic nxt;
        @(posedge clk);
        #1;
    endtask

    task automatic smp;
        @(negedge clk);
    endtask

    initial begin
        reset = 1'b1; init_mem = 1'b1; hang = 1'b0; wait_n = 0;
        if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
        nxt; nxt;
        init_mem = 1'b0;
        smp;
        check("rst_mreq", 32'(m_req), 0);
        check("rst_mwe", 32'(m_we), 0);
        check("rst_ifv", 32'(if_valid), 0);
        check("rst_dv", 32'(d_valid), 0);
        check("rst_berr", 32'(bus_err), 0);
        check("rst_maddr", m_addr, 0);
        check("rst_mwdata", m_wdata, 0);
        nxt;
        reset = 1'b0;

        // fetch-only stream, zero-wait memory
        if_req = 1;
        for (int i = 0; i < 3; i++) begin
            if_addr = 32'(i * 4);
            smp;
            check("f_stall", 32'(stall_f), 1);
            check("f_idle_mreq", 32'(m_req), 0);
            nxt; smp;
            check("f_mreq", 32'(m_req), 1);
            check("f_maddr", m_addr, 32'(i * 4));
            check("f_valid", 32'(if_valid), 1);
            check("f_rdata", if_rdata, 32'hA0 + 32'(i));
            check("f_nostall", 32'(stall_f), 0);
            nxt;
        end
        if_req = 0;

        // simultaneous load and fetch: data first
        d_req = 1; d_we = 0; d_addr = 32'h40; if_req = 1; if_addr = 32'h8;
        smp;
        check("s_stall_m", 32'(stall_m), 1);
        check("s_stall_f", 32'(stall_f), 1);
        nxt; smp;
        check("s_dvalid", 32'(d_valid), 1);
        check("s_drdata", d_rdata, 32'h1234);
        check("s_ifv_low", 32'(if_valid), 0);
        check("s_stall_f2", 32'(stall_f), 1);
        nxt;
        d_req = 0;
        smp;
        check("s_idle_mreq", 32'(m_req), 0);
        check("s_stall_f3", 32'(stall_f), 1);
        nxt; smp;
        check("s_ifvalid", 32'(if_valid), 1);
        check("s_ifrdata", if_rdata, 32'hA2);
        check("s_maddr", m_addr, 32'h8);
        nxt;
        if_req = 0;

        // store with 3 wait states; inputs change while busy
        wait_n = 3; d_req = 1; d_we = 1; d_addr = 32'h60; d_wdata = 32'hDEADBEEF;
        smp; nxt;
        d_addr = 32'h99; d_wdata = 0;
        for (int k = 0; k < 3; k++) begin
            smp;
            check("w_mreq", 32'(m_req), 1);
            check("w_mwe", 32'(m_we), 1);
            check("w_dvalid_low", 32'(d_valid), 0);
            check("w_maddr", m_addr, 32'h60);
            check("w_mwdata", m_wdata, 32'hDEADBEEF);
            nxt;
        end
        smp;
        check("w_mwe_last", 32'(m_we), 1);
        check("w_dvalid", 32'(d_valid), 1);
        nxt;
        wait_n = 0; d_we = 0; d_addr = 32'h60;
        smp; nxt; smp;
        check("w_rb_valid", 32'(d_valid), 1);
        check("w_rb_data", d_rdata, 32'hDEADBEEF);
        nxt;
        d_req = 0;

        // watchdog abort on a fetch
        hang = 1; if_req = 1; if_addr = 32'h10;
        smp; nxt;
        for (int k = 0; k < 4; k++) begin
            smp;
            check("t_mreq", 32'(m_req), 1);
            check("t_ifv_low", 32'(if_valid), 0);
            nxt;
        end
        smp;
        check("t_ifvalid", 32'(if_valid), 1);
        check("t_mreq_low", 32'(m_req), 0);
        check("t_nop", if_rdata, 32'h0000_0013);
        check("t_berr_pre", 32'(bus_err), 0);
        nxt;
        if_req = 0; hang = 0;
        smp;
        check("t_berr", 32'(bus_err), 1);
        nxt; nxt; nxt; smp;
        check("t_berr_sticky", 32'(bus_err), 1);
        nxt;

        // reset lands on the cycle the store would be acknowledged
        wait_n = 3; d_req = 1; d_we = 1; d_addr = 32'h70; d_wdata = 32'h55;
        smp; nxt; smp;
        check("r_mreq", 32'(m_req), 1);
        nxt; smp; nxt; smp; nxt;
        reset = 1; d_req = 0;
        smp;
        check("r_mreq_low", 32'(m_req), 0);
        check("r_mwe_low", 32'(m_we), 0);
        check("r_dvalid_low", 32'(d_valid), 0);
        nxt;
        reset = 0;
        smp;
        check("r_berr_clr", 32'(bus_err), 0);
        check("r_idle", 32'(m_req), 0);
        nxt;
        wait_n = 0; d_req = 1; d_we = 0; d_addr = 32'h70;
        smp; nxt; smp;
        check("r_rb_valid", 32'(d_valid), 1);
        check("r_rb_data", d_rdata, 32'h777);
        nxt;
        d_req = 0;

        // back-to-back loads held by d_req, fetch pending throughout
        if_req = 1; if_addr = 0; d_req = 1; d_we = 0;
        for (int i = 0; i < 3; i++) begin
            d_addr = 32'h50 + 32'(4 * i);
            smp;
            check("b_gap", 32'(d_valid), 0);
            nxt; smp;
            check("b_dvalid", 32'(d_valid), 1);
            check("b_drdata", d_rdata, 32'h5050 + 32'(i * 32'h101));
            check("b_ifv_low", 32'(if_valid), 0);
            nxt;
        end
        d_req = 0;
        smp;
        check("b_idle_ifv", 32'(if_valid), 0);
        check("b_idle_mreq", 32'(m_req), 0);
        nxt; smp;
        check("b_ifvalid", 32'(if_valid), 1);
        check("b_ifrdata", if_rdata, 32'hA0);
        nxt;
        if_req = 0;
        smp;
        check("excl", 32'(both_hi), 0);
        check("dv_count", 32'(dv_cnt), 7);
        check("iv_count", 32'(iv_cnt), 6);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
